// File: rtl/fft_sequencer_pkg.sv
// Shared FSM state type, frame-size limit and power-of-two helpers for the
// FFT sequencer and its address generator.
package fft_sequencer_fsm;

   localparam int SEQ_ADDR_WIDTH = 12;
   localparam int NMAX           = 1 << (SEQ_ADDR_WIDTH - 1);

   typedef enum logic [1:0] {
      seq_IDLE,
      seq_RUN,
      seq_DRAIN,
      seq_DONE
   } seq_fsm;

   function automatic logic is_pow2(input logic [15:0] n);
      return (n != 16'd0) && ((n & (n - 16'd1)) == 16'd0);
   endfunction

   // Index of the highest set bit; exact log2 for a power of two.
   function automatic logic [3:0] log2(input logic [15:0] n);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (n[i]) r = 4'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Per-stage butterfly address generator: a j counter inside each group and a
// running group base, giving A, B = A + h and the twiddle index with shifts only.
module fft_addr_gen
   import fft_sequencer_fsm::*;
#(
   parameter int ADDR_WIDTH = SEQ_ADDR_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_clear,
   input  logic                  i_step,
   input  logic [3:0]            i_stage,
   input  logic [3:0]            i_log2n,
   input  logic [ADDR_WIDTH-1:0] i_n,
   output logic [ADDR_WIDTH-1:0] o_addr_a,
   output logic [ADDR_WIDTH-1:0] o_addr_b,
   output logic [ADDR_WIDTH-3:0] o_tw,
   output logic                  o_last
);

   logic [ADDR_WIDTH-1:0] j_q, j_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH-1:0] span;
   logic [ADDR_WIDTH-1:0] half;
   logic [3:0]            tw_shift;
   logic                  group_end;

   // span = 2h is the group stride; TW = j << (s + log2(NMAX/N)).
   assign span      = i_n >> i_stage;
   assign half      = span >> 1;
   assign tw_shift  = i_stage + 4'(ADDR_WIDTH - 1) - i_log2n;
   assign group_end = (j_q == half - ADDR_WIDTH'(1));

   assign o_addr_a = base_q + j_q;
   assign o_addr_b = o_addr_a + half;
   assign o_tw     = (ADDR_WIDTH-2)'(j_q << tw_shift);
   assign o_last   = group_end && (base_q + span == i_n);

   always_comb begin
      j_d    = j_q;
      base_d = base_q;
      if (i_clear) begin
         j_d    = '0;
         base_d = '0;
      end else if (i_step) begin
         if (group_end) begin
            j_d    = '0;
            base_d = base_q + span;
         end else begin
            j_d = j_q + ADDR_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         j_q    <= '0;
         base_q <= '0;
      end else begin
         j_q    <= j_d;
         base_q <= base_d;
      end
   end

endmodule

// File: rtl/fft_sequencer.sv
// In-place radix-2 DIF FFT controller: stage/butterfly FSM over the sample RAM
// with a write-back delay line matching RAM read plus butterfly latency.
module fft_sequencer
   import fft_sequencer_fsm::*;
#(
   parameter int ADDR_WIDTH  = SEQ_ADDR_WIDTH,
   parameter int BF_LATENCY  = 2,
   parameter int RAM_LATENCY = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_DATA_LOADED,
   input  logic [ADDR_WIDTH-1:0] i_SAMPLES_NUMBER,
   output logic                  o_RAM_OWN,
   output logic                  o_RD_EN,
   output logic [ADDR_WIDTH-1:0] o_RD_ADDR_A,
   output logic [ADDR_WIDTH-1:0] o_RD_ADDR_B,
   output logic [ADDR_WIDTH-3:0] o_TW_INDEX,
   output logic                  o_WR_EN,
   output logic [ADDR_WIDTH-1:0] o_WR_ADDR_A,
   output logic [ADDR_WIDTH-1:0] o_WR_ADDR_B,
   output logic [3:0]            o_STAGE,
   output logic                  o_BUSY,
   output logic                  o_CALC_END,
   output logic                  o_ERR
);

   localparam int DEPTH  = RAM_LATENCY + BF_LATENCY;
   localparam int CW     = $clog2(DEPTH + 1);
   localparam int NMAX_L = 1 << (ADDR_WIDTH - 1);

   seq_fsm                state_q, state_d;
   logic [3:0]            stage_q, stage_d;
   logic [3:0]            log2n_q, log2n_d;
   logic [ADDR_WIDTH-1:0] n_q, n_d;
   logic [CW-1:0]         drain_q, drain_d;
   logic                  err_q, err_d;
   logic                  clear, step, last, rd_en, n_valid;
   logic [ADDR_WIDTH-1:0] addr_a, addr_b;
   logic [ADDR_WIDTH-3:0] tw;

   assign n_valid = is_pow2(16'(i_SAMPLES_NUMBER))
                 && (i_SAMPLES_NUMBER >= ADDR_WIDTH'(2))
                 && (i_SAMPLES_NUMBER <= ADDR_WIDTH'(NMAX_L));

   fft_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_clear (clear),
      .i_step  (step),
      .i_stage (stage_q),
      .i_log2n (log2n_q),
      .i_n     (n_q),
      .o_addr_a(addr_a),
      .o_addr_b(addr_b),
      .o_tw    (tw),
      .o_last  (last)
   );

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      log2n_d = log2n_q;
      n_d     = n_q;
      drain_d = drain_q;
      err_d   = 1'b0;
      clear   = 1'b0;
      step    = 1'b0;
      case (state_q)
         seq_IDLE, seq_DONE: begin
            if (i_DATA_LOADED) begin
               if (n_valid) begin
                  state_d = seq_RUN;
                  n_d     = i_SAMPLES_NUMBER;
                  log2n_d = log2(16'(i_SAMPLES_NUMBER));
                  stage_d = 4'd0;
                  clear   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         seq_RUN: begin
            step = 1'b1;
            if (last) begin
               state_d = seq_DRAIN;
               drain_d = '0;
            end
         end
         seq_DRAIN: begin
            // Wait for the last write of this stage before the next stage reads.
            drain_d = drain_q + CW'(1);
            if (drain_q == CW'(DEPTH - 1)) begin
               if (stage_q == log2n_q - 4'd1) begin
                  state_d = seq_DONE;
               end else begin
                  state_d = seq_RUN;
                  stage_d = stage_q + 4'd1;
                  clear   = 1'b1;
               end
            end
         end
         default: state_d = seq_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= seq_IDLE;
         stage_q <= '0;
         log2n_q <= '0;
         n_q     <= '0;
         drain_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         log2n_q <= log2n_d;
         n_q     <= n_d;
         drain_q <= drain_d;
         err_q   <= err_d;
      end
   end

   assign rd_en       = (state_q == seq_RUN);
   assign o_RD_EN     = rd_en;
   assign o_RD_ADDR_A = rd_en ? addr_a : '0;
   assign o_RD_ADDR_B = rd_en ? addr_b : '0;
   assign o_TW_INDEX  = rd_en ? tw : '0;
   assign o_RAM_OWN   = (state_q == seq_RUN) || (state_q == seq_DRAIN);
   assign o_BUSY      = o_RAM_OWN;
   assign o_CALC_END  = (state_q == seq_DONE);
   assign o_STAGE     = stage_q;
   assign o_ERR       = err_q;

   logic                  wv_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wa_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wb_q [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_wb_delay
         always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
               wv_q[gi] <= 1'b0;
               wa_q[gi] <= '0;
               wb_q[gi] <= '0;
            end else if (gi == 0) begin
               wv_q[gi] <= rd_en;
               wa_q[gi] <= o_RD_ADDR_A;
               wb_q[gi] <= o_RD_ADDR_B;
            end else begin
               wv_q[gi] <= wv_q[(gi == 0) ? 0 : gi - 1];
               wa_q[gi] <= wa_q[(gi == 0) ? 0 : gi - 1];
               wb_q[gi] <= wb_q[(gi == 0) ? 0 : gi - 1];
            end
         end
      end
   endgenerate

   assign o_WR_EN     = wv_q[DEPTH-1];
   assign o_WR_ADDR_A = wa_q[DEPTH-1];
   assign o_WR_ADDR_B = wb_q[DEPTH-1];

endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer: randomized frames compared against a
// loop-based DIF schedule model (read order, write-back timing, CALC_END cycle).
module tb_fft_sequencer;
   import fft_sequencer_fsm::*;

   localparam int AW = 12;
   localparam int D  = 3;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          loaded = 1'b0;
   logic [AW-1:0] nsamp = '0;

   logic          o_RAM_OWN, o_RD_EN, o_WR_EN, o_BUSY, o_CALC_END, o_ERR;
   logic [AW-1:0] o_RD_ADDR_A, o_RD_ADDR_B, o_WR_ADDR_A, o_WR_ADDR_B;
   logic [AW-3:0] o_TW_INDEX;
   logic [3:0]    o_STAGE;

   fft_sequencer #(.ADDR_WIDTH(AW), .BF_LATENCY(2), .RAM_LATENCY(1)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_DATA_LOADED(loaded), .i_SAMPLES_NUMBER(nsamp),
      .o_RAM_OWN(o_RAM_OWN), .o_RD_EN(o_RD_EN), .o_RD_ADDR_A(o_RD_ADDR_A),
      .o_RD_ADDR_B(o_RD_ADDR_B), .o_TW_INDEX(o_TW_INDEX), .o_WR_EN(o_WR_EN),
      .o_WR_ADDR_A(o_WR_ADDR_A), .o_WR_ADDR_B(o_WR_ADDR_B), .o_STAGE(o_STAGE),
      .o_BUSY(o_BUSY), .o_CALC_END(o_CALC_END), .o_ERR(o_ERR)
   );

   always #5 clk = ~clk;

   logic [6*AW+8:0] all_out;
   assign all_out = {o_RAM_OWN, o_RD_EN, o_RD_ADDR_A, o_RD_ADDR_B, o_TW_INDEX, o_WR_EN,
                     o_WR_ADDR_A, o_WR_ADDR_B, o_STAGE, o_BUSY, o_CALC_END, o_ERR};

   int passed = 0;
   int total  = 0;

   typedef struct {int cyc; int a; int b; int tw; int s;} op_t;
   op_t exp_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Textbook DIF schedule; returns the cycle CALC_END is expected to rise.
   function automatic int build_model(input int n);
      int l, cyc, h;
      op_t op;
      exp_q.delete();
      l = 0;
      while ((1 << l) < n) l++;
      cyc = 1;
      for (int s = 0; s < l; s++) begin
         h = n >> (s + 1);
         for (int k = 0; k < n / 2; k++) begin
            op.cyc = cyc;
            op.a   = 2 * h * (k / h) + (k % h);
            op.b   = op.a + h;
            op.tw  = ((k % h) << s) * (NMAX / n);
            op.s   = s;
            exp_q.push_back(op);
            cyc++;
         end
         cyc += D;
      end
      return cyc;
   endfunction

   task automatic run_frame(input int n, input bit noise, input string tag);
      int cyc, end_exp, end_cyc, rd_i, wr_i, rd_bad, wr_bad, own_bad, raw_bad;
      int pend_s[$];
      string rd_msg, wr_msg;
      end_exp = build_model(n);
      rd_i = 0; wr_i = 0; rd_bad = 0; wr_bad = 0; own_bad = 0; raw_bad = 0;
      end_cyc = -1; rd_msg = ""; wr_msg = "";
      loaded = 1'b1;
      nsamp  = AW'(n);
      tick();
      loaded = 1'b0;
      cyc = 1;
      while (cyc <= end_exp + 20) begin
         if (o_CALC_END) begin
            end_cyc = cyc;
            break;
         end
         if (!o_BUSY || !o_RAM_OWN || o_ERR) own_bad++;
         if (o_RD_EN) begin
            foreach (pend_s[i]) if (pend_s[i] < int'(o_STAGE)) raw_bad++;
            pend_s.push_back(int'(o_STAGE));
            if (rd_i >= exp_q.size() || int'(o_RD_ADDR_A) != exp_q[rd_i].a
                || int'(o_RD_ADDR_B) != exp_q[rd_i].b || int'(o_TW_INDEX) != exp_q[rd_i].tw
                || int'(o_STAGE) != exp_q[rd_i].s || cyc != exp_q[rd_i].cyc) begin
               if (rd_bad == 0) begin
                  if (rd_i < exp_q.size())
                     rd_msg = $sformatf("got cyc=%0d s=%0d (%0d,%0d) tw=%0d, want cyc=%0d s=%0d (%0d,%0d) tw=%0d",
                        cyc, o_STAGE, o_RD_ADDR_A, o_RD_ADDR_B, o_TW_INDEX, exp_q[rd_i].cyc,
                        exp_q[rd_i].s, exp_q[rd_i].a, exp_q[rd_i].b, exp_q[rd_i].tw);
                  else
                     rd_msg = $sformatf("extra read at cyc=%0d", cyc);
               end
               rd_bad++;
            end
            rd_i++;
         end
         if (o_WR_EN) begin
            if (wr_i >= exp_q.size() || int'(o_WR_ADDR_A) != exp_q[wr_i].a
                || int'(o_WR_ADDR_B) != exp_q[wr_i].b || cyc != exp_q[wr_i].cyc + D) begin
               if (wr_bad == 0) begin
                  if (wr_i < exp_q.size())
                     wr_msg = $sformatf("got cyc=%0d (%0d,%0d), want cyc=%0d (%0d,%0d)", cyc,
                        o_WR_ADDR_A, o_WR_ADDR_B, exp_q[wr_i].cyc + D, exp_q[wr_i].a, exp_q[wr_i].b);
                  else
                     wr_msg = $sformatf("extra write at cyc=%0d", cyc);
               end
               wr_bad++;
            end
            wr_i++;
            if (pend_s.size() > 0) void'(pend_s.pop_front());
         end
         if (noise) begin
            loaded = 1'($urandom_range(0, 1));
            nsamp  = AW'($urandom);
         end
         tick();
         cyc++;
      end
      loaded = 1'b0;

      total++;
      if (rd_bad !== 0 || rd_i !== exp_q.size())
         $display("FAIL %s reads: %0d bad, %0d issued, required %0d; %s", tag, rd_bad, rd_i, exp_q.size(), rd_msg);
      else passed++;
      total++;
      if (wr_bad !== 0 || wr_i !== exp_q.size())
         $display("FAIL %s writes: %0d bad, %0d issued, required %0d; %s", tag, wr_bad, wr_i, exp_q.size(), wr_msg);
      else passed++;
      total++;
      if (raw_bad !== 0) $display("FAIL %s raw_hazard: %0d early reads, required 0", tag, raw_bad);
      else passed++;
      total++;
      if (own_bad !== 0) $display("FAIL %s busy_own: %0d bad cycles, required 0", tag, own_bad);
      else passed++;
      total++;
      if (end_cyc !== end_exp) $display("FAIL %s calc_end_cycle: got %0d, required %0d", tag, end_cyc, end_exp);
      else passed++;
      total++;
      if ({o_RAM_OWN, o_BUSY, o_RD_EN, o_WR_EN} !== 4'b0000)
         $display("FAIL %s done_outputs: own/busy/rd/wr=%b, required 0000", tag, {o_RAM_OWN, o_BUSY, o_RD_EN, o_WR_EN});
      else passed++;
      $display("frame %s N=%0d: reads=%0d writes=%0d calc_end@%0d", tag, n, rd_i, wr_i, end_cyc);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) tick();
      total++;
      if (all_out !== '0) $display("FAIL reset_outputs: got %h, required 0", all_out);
      else passed++;
      rstn = 1'b1;
      tick();
      total++;
      if (all_out !== '0) $display("FAIL idle_outputs: got %h, required 0", all_out);
      else passed++;
   endtask

   task automatic test_errors(input bit from_done);
      int vals[$];
      int v, errs, rds, bad;
      vals = '{6, 0, 4096, 1, 3, 4095};
      do v = int'($urandom_range(0, 4095)); while (v >= 2 && (v & (v - 1)) == 0);
      vals.push_back(v);
      foreach (vals[i]) begin
         loaded = 1'b1;
         nsamp  = AW'(vals[i]);
         tick();
         loaded = 1'b0;
         errs = 0; rds = 0; bad = 0;
         for (int c = 0; c < 6; c++) begin
            if (o_ERR) errs++;
            if (o_RD_EN || o_WR_EN) rds++;
            if (o_BUSY || o_RAM_OWN || (o_CALC_END !== from_done)) bad++;
            tick();
         end
         total++;
         if (errs !== 1) $display("FAIL err_pulse N=%0d: %0d cycles high, required 1", vals[i], errs);
         else passed++;
         total++;
         if (rds !== 0 || bad !== 0)
            $display("FAIL err_no_start N=%0d: %0d accesses %0d state errors, required 0", vals[i], rds, bad);
         else passed++;
         $display("invalid N=%0d from_done=%0d: err_cycles=%0d", vals[i], from_done, errs);
      end
   endtask

   task automatic test_done_hold();
      int bad;
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         nsamp = AW'($urandom);
         if (!o_CALC_END || o_RAM_OWN || o_BUSY || o_RD_EN || o_WR_EN) bad++;
         tick();
      end
      total++;
      if (bad !== 0) $display("FAIL done_hold: %0d bad cycles, required 0", bad);
      else passed++;
      $display("done held 50 cycles, bad=%0d", bad);
   endtask

   task automatic test_random_frames();
      int n;
      for (int i = 0; i < 5; i++) begin
         n = 1 << $urandom_range(1, 8);
         run_frame(n, 1'b1, $sformatf("rand%0d", i));
      end
   endtask

   task automatic test_reset_midframe();
      int cyc, acts;
      loaded = 1'b1;
      nsamp  = AW'(8);
      tick();
      loaded = 1'b0;
      cyc = 1;
      while (cyc < 10) begin
         tick();
         cyc++;
      end
      total++;
      if (o_RD_EN !== 1'b1) $display("FAIL midframe_running: rd_en=%b, required 1", o_RD_EN);
      else passed++;
      rstn = 1'b0;
      #1;
      total++;
      if (all_out !== '0) $display("FAIL async_reset_outputs: got %h, required 0", all_out);
      else passed++;
      tick();
      tick();
      rstn = 1'b1;
      acts = 0;
      for (int c = 0; c < 30; c++) begin
         if (o_WR_EN || o_RD_EN || o_BUSY || o_CALC_END || o_ERR) acts++;
         tick();
      end
      total++;
      if (acts !== 0) $display("FAIL post_reset_quiet: %0d active cycles, required 0", acts);
      else passed++;
      $display("reset at cycle 10 of N=8 frame, activity after release=%0d", acts);
   endtask

   initial begin
      test_reset();
      test_errors(1'b0);
      run_frame(8, 1'b0, "n8");
      run_frame(2, 1'b0, "n2");
      test_done_hold();
      run_frame(8, 1'b1, "n8_restart");
      test_errors(1'b1);
      test_random_frames();
      run_frame(2048, 1'b1, "n2048");
      test_reset_midframe();
      run_frame(16, 1'b0, "n16_after_reset");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
